dual_port_ram_be: RTL



---
 rtl/dpram_pkg.sv | 23 ++
 rtl/dual_port_ram_be_if.sv | 50 +++++
 rtl/dpram_rd_pipe.sv | 56 +++++
 rtl/dual_port_ram_be.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : dpram_pkg                                                     |
// | Brief    : Shared types and constants for dual_port_ram_be.              |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package dpram_pkg;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int c_RD_LAT_MIN = 1;
    localparam int c_RD_LAT_MAX = 2;

    function automatic int nbytes(input int data_width);
        return data_width / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dual_port_ram_be_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : dual_port_ram_be_if                                           |
// | Brief    : Port A (r/w) and port B (read) bus; perr lines only when      |
// |            DPRAM_PARITY_EN is defined.                                   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface dual_port_ram_be_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    localparam int NBYTES = dpram_pkg::nbytes(DATA_WIDTH);

    logic                  init_busy;
    logic                  a_cs;
    logic                  a_we;
    logic [NBYTES-1:0]     a_be;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic [DATA_WIDTH-1:0] a_rdata;
    logic                  a_rvalid;
    logic                  b_cs;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_rdata;
    logic                  b_rvalid;
`ifdef DPRAM_PARITY_EN
    logic                  a_perr;
    logic                  b_perr;

    modport master (
        input  init_busy, a_rdata, a_rvalid, a_perr, b_rdata, b_rvalid, b_perr,
        output a_cs, a_we, a_be, a_addr, a_wdata, b_cs, b_addr
    );
    modport slave (
        output init_busy, a_rdata, a_rvalid, a_perr, b_rdata, b_rvalid, b_perr,
        input  a_cs, a_we, a_be, a_addr, a_wdata, b_cs, b_addr
    );
`else
    modport master (
        input  init_busy, a_rdata, a_rvalid, b_rdata, b_rvalid,
        output a_cs, a_we, a_be, a_addr, a_wdata, b_cs, b_addr
    );
    modport slave (
        output init_busy, a_rdata, a_rvalid, b_rdata, b_rvalid,
        input  a_cs, a_we, a_be, a_addr, a_wdata, b_cs, b_addr
    );
`endif
endinterface
`default_nettype wire

// File: rtl/dpram_rd_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : dpram_rd_pipe                                                 |
// | Brief    : 1- or 2-stage read data/valid pipeline, synchronous clear.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module dpram_rd_pipe #(
    parameter int LATENCY = 1,
    parameter int WIDTH   = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_valid,
    input  wire logic [WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_data
);
    logic             r_v1;
    logic [WIDTH-1:0] r_d1;

    // Data only loads on a valid beat so the output holds between strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_d1 <= '0;
        end else begin
            r_v1 <= i_valid;
            if (i_valid) r_d1 <= i_data;
        end
    end

    generate
        if (LATENCY >= 2) begin : g_two
            logic             r_v2;
            logic [WIDTH-1:0] r_d2;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_v2 <= 1'b0;
                    r_d2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) r_d2 <= r_d1;
                end
            end

            assign o_valid = r_v2;
            assign o_data  = r_d2;
        end else begin : g_one
            assign o_valid = r_v1;
            assign o_data  = r_d1;
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/dual_port_ram_be.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : dual_port_ram_be                                              |
// | Brief    : Byte-enable RAM, port A r/w + port B read, write-first        |
// |            forwarding, zero sweep after reset. DPRAM_PARITY_EN adds      |
// |            per-byte even parity and a_perr/b_perr.                       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module dual_port_ram_be
    import dpram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int INIT_ZERO  = 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    dual_port_ram_be_if.slave bus
);
    localparam int NBYTES = nbytes(DATA_WIDTH);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
`ifdef DPRAM_PARITY_EN
    localparam int PAY_W  = DATA_WIDTH + 1;
`else
    localparam int PAY_W  = DATA_WIDTH;
`endif

    generate
        if (RD_LATENCY < c_RD_LAT_MIN || RD_LATENCY > c_RD_LAT_MAX) begin : g_bad_latency
            $error("dual_port_ram_be: RD_LATENCY must be 1 or 2");
        end
        if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
            $error("dual_port_ram_be: DATA_WIDTH must be a multiple of 8");
        end
    endgenerate

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic                  w_ready;
    logic                  w_wr;
    logic                  w_a_rd;
    logic                  w_b_rd;
    logic                  w_b_hit;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [NBYTES-1:0]     w_mem_be;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] w_a_mem;
    logic [DATA_WIDTH-1:0] w_b_mem;
    logic [DATA_WIDTH-1:0] w_b_word;
    logic                  r_a_v;
    logic                  r_b_v;
    logic [DATA_WIDTH-1:0] r_a_word;
    logic [DATA_WIDTH-1:0] r_b_word;
    logic [PAY_W-1:0]      w_a_pay;
    logic [PAY_W-1:0]      w_b_pay;
    logic [PAY_W-1:0]      w_a_out;
    logic [PAY_W-1:0]      w_b_out;
    logic                  w_a_ov;
    logic                  w_b_ov;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= (INIT_ZERO != 0) ? ST_INIT : ST_READY;
            r_init_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_init_cnt <= r_init_cnt + 1'b1;
            if (&r_init_cnt) r_state <= ST_READY;
        end
    end

    assign bus.init_busy = (r_state == ST_INIT);
    assign w_ready       = (r_state == ST_READY);
    assign w_wr          = w_ready & bus.a_cs & bus.a_we;
    assign w_a_rd        = w_ready & bus.a_cs & ~bus.a_we;
    assign w_b_rd        = w_ready & bus.b_cs;
    assign w_b_hit       = w_wr & (bus.b_addr == bus.a_addr);

    // Single write port shared by the sweep and port A.
    always_comb begin
        w_mem_addr  = bus.a_addr;
        w_mem_wdata = bus.a_wdata;
        w_mem_be    = '0;
        if (!rst_n) begin
            w_mem_be = '0;
        end else if (r_state == ST_INIT) begin
            w_mem_addr  = r_init_cnt;
            w_mem_wdata = '0;
            w_mem_be    = '1;
        end else if (w_wr) begin
            w_mem_be = bus.a_be;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (w_mem_be[i]) r_mem[w_mem_addr][8*i +: 8] <= w_mem_wdata[8*i +: 8];
        end
    end

    assign w_a_mem = r_mem[bus.a_addr];
    assign w_b_mem = r_mem[bus.b_addr];

    // Write-first: B sees A's enabled bytes when both hit the same word.
    always_comb begin
        w_b_word = w_b_mem;
        for (int i = 0; i < NBYTES; i++) begin
            if (w_b_hit && bus.a_be[i]) w_b_word[8*i +: 8] = bus.a_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_v    <= 1'b0;
            r_b_v    <= 1'b0;
            r_a_word <= '0;
            r_b_word <= '0;
        end else begin
            r_a_v <= w_a_rd;
            r_b_v <= w_b_rd;
            if (w_a_rd) r_a_word <= w_a_mem;
            if (w_b_rd) r_b_word <= w_b_word;
        end
    end

`ifdef DPRAM_PARITY_EN
    logic [NBYTES-1:0] r_par [DEPTH];
    logic [NBYTES-1:0] w_b_par;
    logic [NBYTES-1:0] r_a_par;
    logic [NBYTES-1:0] r_b_par;

    function automatic logic [NBYTES-1:0] f_parity(input logic [DATA_WIDTH-1:0] d);
        logic [NBYTES-1:0] p;
        for (int i = 0; i < NBYTES; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction

    always_ff @(posedge clk) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (w_mem_be[i]) r_par[w_mem_addr][i] <= ^w_mem_wdata[8*i +: 8];
        end
    end

    always_comb begin
        w_b_par = r_par[bus.b_addr];
        for (int i = 0; i < NBYTES; i++) begin
            if (w_b_hit && bus.a_be[i]) w_b_par[i] = ^bus.a_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_par <= '0;
            r_b_par <= '0;
        end else begin
            if (w_a_rd) r_a_par <= r_par[bus.a_addr];
            if (w_b_rd) r_b_par <= w_b_par;
        end
    end

    assign w_a_pay    = {|(r_a_par ^ f_parity(r_a_word)), r_a_word};
    assign w_b_pay    = {|(r_b_par ^ f_parity(r_b_word)), r_b_word};
    assign bus.a_perr = w_a_ov & w_a_out[DATA_WIDTH];
    assign bus.b_perr = w_b_ov & w_b_out[DATA_WIDTH];
`else
    assign w_a_pay = r_a_word;
    assign w_b_pay = r_b_word;
`endif

    dpram_rd_pipe #(
        .LATENCY (RD_LATENCY),
        .WIDTH   (PAY_W)
    ) u_a_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (r_a_v),
        .i_data  (w_a_pay),
        .o_valid (w_a_ov),
        .o_data  (w_a_out)
    );

    dpram_rd_pipe #(
        .LATENCY (RD_LATENCY),
        .WIDTH   (PAY_W)
    ) u_b_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (r_b_v),
        .i_data  (w_b_pay),
        .o_valid (w_b_ov),
        .o_data  (w_b_out)
    );

    assign bus.a_rvalid = w_a_ov;
    assign bus.a_rdata  = w_a_out[DATA_WIDTH-1:0];
    assign bus.b_rvalid = w_b_ov;
    assign bus.b_rdata  = w_b_out[DATA_WIDTH-1:0];
endmodule
`default_nettype wire
